// File: rtl/cache_pkg.sv
// Shared constants and FSM state type for the direct-mapped read cache controller.
package cache_pkg;
    localparam int ADDR_W         = 32;
    localparam int DATA_W         = 32;
    localparam int INDEX_W        = 8;
    localparam int OFFSET_W       = 4;
    localparam int TAG_W          = ADDR_W - INDEX_W - OFFSET_W;
    localparam int WORDS_PER_LINE = 1 << OFFSET_W;

    typedef enum logic [1:0] {IDLE, LOOKUP, MISS_REQ, REFILL} ctrl_state_t;
endpackage

// File: rtl/cache_tag_store.sv
// Tag array (async read, sync write) plus per-line valid bits cleared by reset.
module cache_tag_store #(
    parameter int INDEX_W = cache_pkg::INDEX_W,
    parameter int TAG_W   = cache_pkg::TAG_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INDEX_W-1:0] index,
    output logic [TAG_W-1:0]   rd_tag,
    output logic               rd_valid,
    input  logic               tag_we,
    input  logic [TAG_W-1:0]   wr_tag,
    input  logic               set_valid,
    input  logic               clr_valid
);
    logic [TAG_W-1:0]        tags [1<<INDEX_W];
    logic [(1<<INDEX_W)-1:0] valid;

    assign rd_tag   = tags[index];
    assign rd_valid = valid[index];

    // Tags carry no reset; a line is only trusted through its valid bit.
    always_ff @(posedge clk) begin
        if (tag_we) tags[index] <= wr_tag;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)            valid        <= '0;
        else if (set_valid) valid[index] <= 1'b1;
        else if (clr_valid) valid[index] <= 1'b0;
    end
endmodule

// File: rtl/cache_ctrl.sv
// Direct-mapped read cache sequencer: lookup, 16-beat line refill, word return.
// Optional hit/miss counters are enabled by defining CACHE_CTRL_STATS_EN.
module cache_ctrl #(
    parameter int ADDR_W   = cache_pkg::ADDR_W,
    parameter int DATA_W   = cache_pkg::DATA_W,
    parameter int INDEX_W  = cache_pkg::INDEX_W,
    parameter int OFFSET_W = cache_pkg::OFFSET_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cpu_req_valid,
    input  logic [ADDR_W-1:0]           cpu_req_addr,
    output logic                        cpu_req_ready,
    output logic                        cpu_resp_valid,
    output logic [DATA_W-1:0]           cpu_resp_data,
    output logic                        cpu_resp_hit,
    output logic                        mem_req_valid,
    output logic [ADDR_W-1:0]           mem_req_addr,
    input  logic                        mem_req_ready,
    input  logic                        mem_rdata_valid,
    input  logic [DATA_W-1:0]           mem_rdata,
    output logic [INDEX_W+OFFSET_W-1:0] dar_raddr,
    input  logic [DATA_W-1:0]           dar_rdata,
    output logic                        dar_we,
    output logic [INDEX_W+OFFSET_W-1:0] dar_waddr,
    output logic [DATA_W-1:0]           dar_wdata
`ifdef CACHE_CTRL_STATS_EN
    ,
    output logic [31:0]                 stat_hits,
    output logic [31:0]                 stat_misses
`endif
);
    import cache_pkg::*;

    localparam int TW = ADDR_W - INDEX_W - OFFSET_W;

    ctrl_state_t         state, state_nxt;
    logic [ADDR_W-1:0]   req_addr;
    logic [OFFSET_W-1:0] beat;
    logic [DATA_W-1:0]   word_q;
    logic [TW-1:0]       req_tag, stored_tag;
    logic [INDEX_W-1:0]  req_index;
    logic [OFFSET_W-1:0] req_off;
    logic                stored_valid, tag_hit, last_beat;
    logic                tag_we, set_valid, clr_valid, resp_hit_set, resp_miss_set;

    assign req_tag   = req_addr[ADDR_W-1 -: TW];
    assign req_index = req_addr[OFFSET_W +: INDEX_W];
    assign req_off   = req_addr[OFFSET_W-1:0];
    assign tag_hit   = stored_valid && (stored_tag == req_tag);
    assign last_beat = &beat;

    cache_tag_store #(.INDEX_W(INDEX_W), .TAG_W(TW)) u_tags (
        .clk       (clk),
        .rst       (rst),
        .index     (req_index),
        .rd_tag    (stored_tag),
        .rd_valid  (stored_valid),
        .tag_we    (tag_we),
        .wr_tag    (req_tag),
        .set_valid (set_valid),
        .clr_valid (clr_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        cpu_req_ready = 1'b0;
        mem_req_valid = 1'b0;
        mem_req_addr  = '0;
        dar_raddr     = '0;
        dar_we        = 1'b0;
        dar_waddr     = '0;
        dar_wdata     = '0;
        tag_we        = 1'b0;
        set_valid     = 1'b0;
        clr_valid     = 1'b0;
        resp_hit_set  = 1'b0;
        resp_miss_set = 1'b0;
        case (state)
            IDLE: begin
                cpu_req_ready = 1'b1;
                if (cpu_req_valid) begin
                    // Start the data-array read now so the word is ready in LOOKUP.
                    dar_raddr = cpu_req_addr[INDEX_W+OFFSET_W-1:0];
                    state_nxt = LOOKUP;
                end
            end
            LOOKUP: begin
                if (tag_hit) begin
                    resp_hit_set = 1'b1;
                    state_nxt    = IDLE;
                end else begin
                    clr_valid = 1'b1;
                    state_nxt = MISS_REQ;
                end
            end
            MISS_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = {req_tag, req_index, {OFFSET_W{1'b0}}};
                if (mem_req_ready) state_nxt = REFILL;
            end
            REFILL: begin
                if (mem_rdata_valid) begin
                    dar_we    = 1'b1;
                    dar_waddr = {req_index, beat};
                    dar_wdata = mem_rdata;
                    if (last_beat) begin
                        tag_we        = 1'b1;
                        set_valid     = 1'b1;
                        resp_miss_set = 1'b1;
                        state_nxt     = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_addr       <= '0;
            beat           <= '0;
            word_q         <= '0;
            cpu_resp_valid <= 1'b0;
            cpu_resp_hit   <= 1'b0;
            cpu_resp_data  <= '0;
        end else begin
            cpu_resp_valid <= 1'b0;
            if (state == IDLE && cpu_req_valid) req_addr <= cpu_req_addr;
            if (state == MISS_REQ && mem_req_ready) beat <= '0;
            if (dar_we) begin
                if (!last_beat) beat <= beat + 1'b1;
                if (beat == req_off) word_q <= mem_rdata;
            end
            if (resp_hit_set) begin
                cpu_resp_valid <= 1'b1;
                cpu_resp_hit   <= 1'b1;
                cpu_resp_data  <= dar_rdata;
            end
            // The requested word may be the final beat itself, so bypass word_q then.
            if (resp_miss_set) begin
                cpu_resp_valid <= 1'b1;
                cpu_resp_hit   <= 1'b0;
                cpu_resp_data  <= (beat == req_off) ? mem_rdata : word_q;
            end
        end
    end

`ifdef CACHE_CTRL_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_hits   <= '0;
            stat_misses <= '0;
        end else begin
            if (resp_hit_set && stat_hits != '1)    stat_hits   <= stat_hits + 32'd1;
            if (resp_miss_set && stat_misses != '1) stat_misses <= stat_misses + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_cache_ctrl.sv
// Randomized bench for cache_ctrl against a line-level reference model of the cache.
module tb_cache_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_req_valid = 1'b0;
    logic [31:0] cpu_req_addr = '0;
    logic        cpu_req_ready;
    logic        cpu_resp_valid;
    logic [31:0] cpu_resp_data;
    logic        cpu_resp_hit;
    logic        mem_req_valid;
    logic [31:0] mem_req_addr;
    logic        mem_req_ready = 1'b0;
    logic        mem_rdata_valid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic [11:0] dar_raddr;
    logic [31:0] dar_rdata;
    logic        dar_we;
    logic [11:0] dar_waddr;
    logic [31:0] dar_wdata;
`ifdef CACHE_CTRL_STATS_EN
    logic [31:0] stat_hits, stat_misses;
`endif

    cache_ctrl dut (
        .clk(clk), .rst(rst),
        .cpu_req_valid(cpu_req_valid), .cpu_req_addr(cpu_req_addr), .cpu_req_ready(cpu_req_ready),
        .cpu_resp_valid(cpu_resp_valid), .cpu_resp_data(cpu_resp_data), .cpu_resp_hit(cpu_resp_hit),
        .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_ready(mem_req_ready),
        .mem_rdata_valid(mem_rdata_valid), .mem_rdata(mem_rdata),
        .dar_raddr(dar_raddr), .dar_rdata(dar_rdata), .dar_we(dar_we),
        .dar_waddr(dar_waddr), .dar_wdata(dar_wdata)
`ifdef CACHE_CTRL_STATS_EN
        , .stat_hits(stat_hits), .stat_misses(stat_misses)
`endif
    );

    always #5 clk = ~clk;

    // External data array: synchronous write, one-cycle synchronous read.
    logic [31:0] dar_mem [4096];
    always @(posedge clk) begin
        if (dar_we) dar_mem[dar_waddr] <= dar_wdata;
        dar_rdata <= dar_mem[dar_raddr];
    end

    int n_chk = 0;
    int n_err = 0;

    // Reference cache contents: what each line should hold after completed refills.
    bit          ref_valid [256];
    logic [19:0] ref_tag   [256];
    logic [31:0] ref_line  [256][16];
    int          ref_hits = 0;
    int          ref_misses = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Issue one read at the current negedge and play the memory side; abort_at>=0
    // asserts reset right after that beat has been accepted.
    task automatic do_read(input logic [31:0] addr, input int rdy_dly, input int max_gap,
                           input logic [31:0] base, input int abort_at);
        logic [7:0]  idx;
        logic [3:0]  off;
        logic [19:0] tag;
        bit          exp_hit;
        int          g;
        idx = addr[11:4];
        off = addr[3:0];
        tag = addr[31:12];
        exp_hit = ref_valid[idx] && (ref_tag[idx] == tag);

        cpu_req_valid = 1'b1;
        cpu_req_addr  = addr;
        #1;
        chk("req_ready", cpu_req_ready, 1);
        chk("dar_raddr", dar_raddr, addr[11:0]);
        @(negedge clk);
        cpu_req_valid = 1'b0;
        cpu_req_addr  = $urandom;
        chk("busy_ready", cpu_req_ready, 0);
        chk("lookup_resp", cpu_resp_valid, 0);
        chk("lookup_mreq", mem_req_valid, 0);

        if (exp_hit) begin
            @(negedge clk);
            chk("hit_valid", cpu_resp_valid, 1);
            chk("hit_flag", cpu_resp_hit, 1);
            chk("hit_data", cpu_resp_data, ref_line[idx][off]);
            ref_hits++;
            return;
        end

        @(negedge clk);
        for (int c = 0; c <= rdy_dly; c++) begin
            chk("mreq_valid", mem_req_valid, 1);
            chk("mreq_addr", mem_req_addr, {addr[31:4], 4'h0});
            chk("mreq_resp", cpu_resp_valid, 0);
            if (c < rdy_dly) @(negedge clk);
        end
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        chk("mreq_drop", mem_req_valid, 0);

        for (int k = 0; k < 16; k++) begin
            g = int'($urandom_range(max_gap, 0));
            repeat (g) begin
                mem_rdata_valid = 1'b0;
                mem_rdata = $urandom;
                #1;
                chk("gap_we", dar_we, 0);
                chk("gap_resp", cpu_resp_valid, 0);
                @(negedge clk);
            end
            mem_rdata_valid = 1'b1;
            mem_rdata = base + 32'(k);
            #1;
            chk("beat_we", dar_we, 1);
            chk("beat_waddr", dar_waddr, {idx, 4'(k)});
            chk("beat_wdata", dar_wdata, base + 32'(k));
            chk("beat_resp", cpu_resp_valid, 0);
            @(negedge clk);
            if (k == abort_at) begin
                rst = 1'b1;
                mem_rdata = base + 32'(k + 1);
                #1;
                chk("rst_resp", cpu_resp_valid, 0);
                chk("rst_rhit", cpu_resp_hit, 0);
                chk("rst_rdata", cpu_resp_data, 0);
                chk("rst_mreq", mem_req_valid, 0);
                chk("rst_maddr", mem_req_addr, 0);
                chk("rst_we", dar_we, 0);
                @(negedge clk);
                rst = 1'b0;
                repeat (3) begin
                    #1;
                    chk("stray_we", dar_we, 0);
                    chk("stray_resp", cpu_resp_valid, 0);
                    chk("stray_ready", cpu_req_ready, 1);
                    @(negedge clk);
                end
                mem_rdata_valid = 1'b0;
                for (int i = 0; i < 256; i++) ref_valid[i] = 1'b0;
                return;
            end
        end
        mem_rdata_valid = 1'b0;
        chk("miss_valid", cpu_resp_valid, 1);
        chk("miss_flag", cpu_resp_hit, 0);
        chk("miss_data", cpu_resp_data, base + 32'(off));
        ref_valid[idx] = 1'b1;
        ref_tag[idx]   = tag;
        for (int k = 0; k < 16; k++) ref_line[idx][k] = base + 32'(k);
        ref_misses++;
    endtask

    logic [7:0]  idx_pool [4];
    logic [31:0] a;

    initial begin
        for (int i = 0; i < 256; i++) ref_valid[i] = 1'b0;
        idx_pool[0] = 8'h23; idx_pool[1] = 8'h45; idx_pool[2] = 8'h00; idx_pool[3] = 8'hFF;

        repeat (3) @(negedge clk);
        chk("rst_resp_valid", cpu_resp_valid, 0);
        chk("rst_resp_data", cpu_resp_data, 0);
        chk("rst_mreq_valid", mem_req_valid, 0);
        chk("rst_dar_we", dar_we, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_ready", cpu_req_ready, 1);

        do_read(32'h0000_1234, 0, 0, 32'hA0, -1);
        do_read(32'h0000_1238, 0, 0, 32'h0, -1);
        do_read(32'h0000_2234, 2, 1, $urandom, -1);
        do_read(32'h0000_1234, 0, 0, $urandom, -1);
        do_read(32'h0000_456F, 5, 3, $urandom, -1);
        do_read(32'h0000_4560, 0, 0, 32'h0, -1);
        do_read(32'h0000_3234, 1, 2, $urandom, 7);
        do_read(32'h0000_1234, 0, 1, $urandom, -1);

        for (int n = 0; n < 40; n++) begin
            a = {12'h0, 8'(4'($urandom_range(3, 1))), idx_pool[$urandom_range(3, 0)],
                 4'($urandom_range(15, 0))};
            do_read(a, int'($urandom_range(3, 0)), int'($urandom_range(2, 0)), $urandom, -1);
        end

        @(negedge clk);
        chk("final_resp", cpu_resp_valid, 0);
        chk("final_ready", cpu_req_ready, 1);
`ifdef CACHE_CTRL_STATS_EN
        chk("stat_hits", stat_hits, 32'(ref_hits));
        chk("stat_misses", stat_misses, 32'(ref_misses));
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
